// File: rtl/pixel_pkg.sv
// Shared types and sizing constants for the pixel buffer sequencer.
package pixel_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      STREAM = 2'd2,
      DONE   = 2'd3
   } pixseq_state_t;

   localparam int PIX_BYTES      = 72;
   localparam int PIX_PASSES     = 10;
   localparam int PIX_BYTE_CNT_W = $clog2(PIX_BYTES + 1);
   localparam int PIX_PASS_CNT_W = $clog2(PIX_PASSES + 1);

endpackage

// File: rtl/pixseq_counter.sv
// Terminal-count counter: counts 0..MAX-1, returns to 0 on the enabled
// step that hits MAX-1 and flags that step with a combinational pulse.
module pixseq_counter #(
   parameter int MAX = 72,
   parameter int W   = $clog2(MAX + 1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_clr,
   input  logic         i_en,
   output logic [W-1:0] o_cnt,
   output logic         o_tc
);

   localparam logic [W-1:0] LAST = W'(MAX - 1);

   logic [W-1:0] r_cnt;

   assign o_tc  = i_en && (r_cnt == LAST);
   assign o_cnt = r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= o_tc ? '0 : r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/pixel_seq_ctrl.sv
// Load/rotate sequencer for the pixel shift-register buffer.
// Optional sticky overrun flag: define PIXSEQ_OVERRUN_EN.
module pixel_seq_ctrl
   import pixel_pkg::*;
#(
   parameter int NUM_BYTES  = PIX_BYTES,
   parameter int NUM_PASSES = PIX_PASSES
) (
   input  logic clk,
   input  logic rst,
   input  logic spi_byte_valid,
   input  logic net_next,
   input  logic frame_clear,
   output logic shift_SPI,
   output logic write_en,
   output logic shift_network,
   output logic window_valid,
   output logic pass_done,
   output logic frame_done,
   output logic busy
`ifdef PIXSEQ_OVERRUN_EN
   ,
   output logic overrun
`endif
);

   localparam int CNT_W  = $clog2(NUM_BYTES + 1);
   localparam int PASS_W = $clog2(NUM_PASSES + 1);
   localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NUM_BYTES - 1);

   pixseq_state_t r_state, w_state_nxt;

   logic r_shift_spi, r_write_en, r_shift_net, r_window_valid;
   logic r_pass_done, r_frame_done, r_busy;
   logic w_shift_spi_nxt, w_write_en_nxt, w_shift_net_nxt, w_window_nxt;
   logic w_pass_done_nxt, w_frame_done_nxt, w_busy_nxt;

   logic              w_acc_spi, w_acc_net, w_step, w_wrap;
   logic              w_cnt_tc, w_pass_tc, w_pass_clr;
   logic [CNT_W-1:0]  w_cnt;
   logic [PASS_W-1:0] w_pass_cnt;

   // A request is only taken when it can act; a net_next landing on an
   // active rotate cycle is dropped so one request never yields two shifts.
   assign w_acc_spi = !frame_clear && spi_byte_valid && (r_state == IDLE || r_state == LOAD);
   assign w_acc_net = !frame_clear && net_next && !r_shift_net && (r_state == STREAM);
   assign w_step    = r_shift_net && (r_state == STREAM);
   assign w_wrap    = w_cnt_tc && (r_state == STREAM);
   // Pass count only has meaning inside STREAM; keep it parked at zero elsewhere.
   assign w_pass_clr = frame_clear || ((r_state != STREAM) && (w_pass_cnt != '0));

   pixseq_counter #(
      .MAX (NUM_BYTES),
      .W   (CNT_W)
   ) u_byte_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_clr (frame_clear),
      .i_en  (w_acc_spi || w_step),
      .o_cnt (w_cnt),
      .o_tc  (w_cnt_tc)
   );

   pixseq_counter #(
      .MAX (NUM_PASSES),
      .W   (PASS_W)
   ) u_pass_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_clr (w_pass_clr),
      .i_en  (w_wrap),
      .o_cnt (w_pass_cnt),
      .o_tc  (w_pass_tc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_shift_spi_nxt  = 1'b0;
      w_write_en_nxt   = 1'b0;
      w_shift_net_nxt  = 1'b0;
      w_window_nxt     = 1'b0;
      w_pass_done_nxt  = 1'b0;
      w_frame_done_nxt = 1'b0;
      w_busy_nxt       = 1'b0;

      if (frame_clear) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE:    if (w_acc_spi) w_state_nxt = LOAD;
            LOAD:    if (w_acc_spi && (w_cnt == LAST_BYTE)) w_state_nxt = STREAM;
            STREAM:  if (w_pass_tc) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
         endcase
      end

      w_shift_spi_nxt  = w_acc_spi;
      w_write_en_nxt   = w_acc_spi;
      w_shift_net_nxt  = w_acc_net;
      w_pass_done_nxt  = !frame_clear && w_wrap;
      w_frame_done_nxt = !frame_clear && (r_state == DONE);
      // Window is withheld on the entry edge so it rises one cycle after the last load shift.
      w_window_nxt     = (r_state == STREAM) && (w_state_nxt == STREAM) && !w_acc_net;
      w_busy_nxt       = (w_state_nxt != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shift_spi    <= 1'b0;
         r_write_en     <= 1'b0;
         r_shift_net    <= 1'b0;
         r_window_valid <= 1'b0;
         r_pass_done    <= 1'b0;
         r_frame_done   <= 1'b0;
         r_busy         <= 1'b0;
      end else begin
         r_shift_spi    <= w_shift_spi_nxt;
         r_write_en     <= w_write_en_nxt;
         r_shift_net    <= w_shift_net_nxt;
         r_window_valid <= w_window_nxt;
         r_pass_done    <= w_pass_done_nxt;
         r_frame_done   <= w_frame_done_nxt;
         r_busy         <= w_busy_nxt;
      end
   end

   assign shift_SPI     = r_shift_spi;
   assign write_en      = r_write_en;
   assign shift_network = r_shift_net;
   assign window_valid  = r_window_valid;
   assign pass_done     = r_pass_done;
   assign frame_done    = r_frame_done;
   assign busy          = r_busy;

`ifdef PIXSEQ_OVERRUN_EN
   logic r_overrun;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_overrun <= 1'b0;
      end else if (frame_clear) begin
         r_overrun <= 1'b0;
      end else if (spi_byte_valid && (r_state == STREAM || r_state == DONE)) begin
         r_overrun <= 1'b1;
      end
   end

   assign overrun = r_overrun;
`endif

endmodule

// File: doc/pixel_seq_ctrl.md
# pixel_seq_ctrl

Sequencer for the 72-byte pixel shift-register buffer. It loads one frame of bytes from the SPI receiver, then rotates the buffer one byte per network request so the classifier sees a sliding two-pixel window. It repeats the full rotation for a programmable number of passes (one per neuron group) and then releases the buffer for the next frame. It sits between the SPI slave, the pixel buffer and the network datapath, and is the only driver of the buffer's shift and write-enable controls.

## Interface
- NUM_BYTES, 72, bytes held in the pixel buffer; one pass is exactly NUM_BYTES shifts.
- NUM_PASSES, 10, full rotations per frame before the buffer is released.
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- spi_byte_valid  in  1  one-cycle pulse: SPI receiver has a new byte on its output.
- net_next  in  1  one-cycle pulse: network consumed the current window and wants the next one.
- frame_clear  in  1  synchronous abort; returns to IDLE next cycle.
- shift_SPI  out  1  buffer shift, load path.
- write_en  out  1  buffer input mux select, 1 = SPI byte.
- shift_network  out  1  buffer shift, rotate path.
- window_valid  out  1  pixel_data_1/2 outputs of the buffer hold a stable, valid window.
- pass_done  out  1  one-cycle pulse at the end of each pass.
- frame_done  out  1  one-cycle pulse after the last pass.
- busy  out  1  high in every state except IDLE.
- overrun  out  1  sticky error flag. Exists only with PIXSEQ_OVERRUN_EN.

## Operation
- States: IDLE, LOAD, STREAM, DONE. All outputs are registered.
- IDLE
  - spi_byte_valid: shift_SPI=1 and write_en=1 next cycle; byte_cnt=1; go to LOAD.
- LOAD
  - Each spi_byte_valid produces one shift_SPI+write_en cycle and byte_cnt+1.
  - When the byte_cnt 71→72 byte is accepted: byte_cnt=0, pass_cnt=0, go to STREAM.
  - The first written byte is at the buffer top.
- STREAM
  - window_valid=1 except in the cycle shift_network is high.
  - net_next produces shift_network=1 (write_en=0) next cycle and shift_cnt+1.
  - On the shift that makes shift_cnt==NUM_BYTES, the buffer is back in load order: shift_cnt=0, pass_done pulses, pass_cnt+1.
  - When pass_cnt reaches NUM_PASSES, go to DONE.
- DONE: frame_done=1 for one cycle, then IDLE. window_valid=0.
- spi_byte_valid outside IDLE/LOAD is ignored: no shift.
- net_next outside STREAM is ignored.
- net_next arriving in the same cycle shift_network is high is ignored. The requester must wait for window_valid.
- frame_clear beats all other inputs. All counters go to 0 and all outputs to 0; buffer contents are left untouched.
- Counters: byte_cnt/shift_cnt are $clog2(NUM_BYTES+1) bits and pass_cnt is $clog2(NUM_PASSES+1) bits. They never wrap past their terminal value.
- shift_SPI and shift_network are never high in the same cycle.

## Timing
- Reset: every output is 0, state is IDLE, all counters are 0.
- spi_byte_valid or net_next at edge N → the matching shift is high during cycle N+1, one cycle wide.
- Load of 72 bytes back-to-back: STREAM is entered and window_valid=1 one cycle after the last shift_SPI.
- The final shift of the last pass is followed by pass_done and DONE in the next cycle, then frame_done, then IDLE: 2 cycles total.
- Reset asserted mid-LOAD or mid-STREAM clears everything immediately. The partially loaded buffer must be reloaded from scratch.

## Configuration
- PIXSEQ_OVERRUN_EN defined:
  - overrun port exists.
  - overrun is set when spi_byte_valid arrives in STREAM or DONE.
  - It is cleared only by rst or frame_clear.
- PIXSEQ_OVERRUN_EN undefined: no port, no register; such bytes are silently dropped.

## Structure
- Shared package pixel_pkg:
  - state enum pixseq_state_t {IDLE, LOAD, STREAM, DONE}.
  - localparams PIX_BYTES=72 and PIX_PASSES default.
  - counter-width constants.
- One natural sub-module, pixseq_counter: a parameterized terminal-count counter with clear, enable, count and terminal-count pulse. It is instantiated for byte/shift count and for pass count. The FSM stays in the top.

## Test plan
- Reset mid-LOAD after 30 bytes → all outputs 0, IDLE. A following 72-byte load enters STREAM normally.
- 72 back-to-back spi_byte_valid → exactly 72 shift_SPI cycles each with write_en=1, then window_valid=1 one cycle later.
- STREAM with NUM_PASSES=2 and 144 net_next pulses → 144 shift_network pulses, pass_done after shifts 72 and 144, frame_done one cycle after the second pass_done, then IDLE.
- net_next issued while shift_network is high → no extra shift; shift_cnt advances by 1 only.
- spi_byte_valid in STREAM → no shift_SPI. overrun=1 with PIXSEQ_OVERRUN_EN, unchanged behaviour otherwise. frame_clear → overrun=0, IDLE.
- frame_clear and net_next in the same cycle in STREAM → no shift_network; IDLE next cycle with counters 0.
